// File: rtl/cvp14_pkg.sv
// Shared CVP14 definitions for the vector memory stage: sizes, opcodes, FSM states, latched request.
// Also provides the CVP14_LANE(vec, i) macro selecting the 16-bit lane i of a packed vector.
package cvp14_pkg;
  localparam int DATA_W     = 16;
  localparam int LANES      = 16;
  localparam int ADDR_W     = 16;
  localparam int VEC_W      = DATA_W * LANES;
  localparam int LANE_CNT_W = 4;

  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_VLD = 4'b0100;
  localparam logic [3:0] OP_VST = 4'b0101;

  typedef enum logic [2:0] {
    IDLE,
    STORE,
    LOAD,
    DRAIN,
    DONE
  } vmu_state_t;

  typedef struct packed {
    logic [2:0]       dst;
    logic [VEC_W-1:0] wdata;
  } vmu_req_t;
endpackage

`ifndef CVP14_LANE
`define CVP14_LANE(vec, i) vec[(i)*cvp14_pkg::DATA_W +: cvp14_pkg::DATA_W]
`endif

// File: rtl/vmu_addr_gen.sv
// Lane counter plus base/stride accumulator; addr is valid the cycle after start, advances on step.
// No backpressure of its own: the owning FSM decides when to step.
module vmu_addr_gen
  import cvp14_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  step,
  input  logic [ADDR_W-1:0]     base,
  input  logic [ADDR_W-1:0]     stride,
  output logic [ADDR_W-1:0]     addr,
  output logic [LANE_CNT_W-1:0] lane,
  output logic                  last_lane
);
  logic [ADDR_W-1:0] stride_q;

  // Accumulating the stride keeps the adder narrow; the sum wraps naturally mod 2^ADDR_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr     <= '0;
      lane     <= '0;
      stride_q <= '0;
    end else if (start) begin
      addr     <= base;
      lane     <= '0;
      stride_q <= stride;
    end else if (step) begin
      addr <= addr + stride_q;
      lane <= lane + LANE_CNT_W'(1);
    end
  end

  assign last_lane = (lane == LANE_CNT_W'(LANES - 1));
endmodule

// File: rtl/vector_mem_unit.sv
// Vector load/store sequencer: VST done at T+17, VLD done+ld_valid at T+18; req_ready low while busy.
// VMU_STRIDE_EN adds req_stride (lane i at base+i*stride); otherwise lanes are contiguous.
module vector_mem_unit
  import cvp14_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_opcode,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [VEC_W-1:0]  req_wdata,
  input  logic [2:0]        req_dst,
`ifdef VMU_STRIDE_EN
  input  logic [ADDR_W-1:0] req_stride,
`endif
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              ld_valid,
  output logic [VEC_W-1:0]  ld_data,
  output logic [2:0]        ld_dst,
  output logic              done
);
  vmu_state_t            state;
  vmu_req_t              req_q;
  logic                  accept;
  logic                  step;
  logic [ADDR_W-1:0]     stride;
  logic [ADDR_W-1:0]     gen_addr;
  logic [LANE_CNT_W-1:0] lane;
  logic                  last_lane;
  logic                  rd_pend;
  logic [LANE_CNT_W-1:0] rd_lane;

`ifdef VMU_STRIDE_EN
  assign stride = req_stride;
`else
  assign stride = ADDR_W'(1);
`endif

  // Unknown opcodes are never handshaken, so they leave no trace in the unit.
  assign accept = req_valid && req_ready && (req_opcode == OP_VLD || req_opcode == OP_VST);
  assign step   = mem_we | mem_re;

  vmu_addr_gen u_addr_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (accept),
    .step      (step),
    .base      (req_addr),
    .stride    (stride),
    .addr      (gen_addr),
    .lane      (lane),
    .last_lane (last_lane)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      done      <= 1'b0;
      ld_valid  <= 1'b0;
      ld_dst    <= '0;
      req_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            req_q     <= '{dst: req_dst, wdata: req_wdata};
            req_ready <= 1'b0;
            if (req_opcode == OP_VST) begin
              state  <= STORE;
              mem_we <= 1'b1;
            end else begin
              state  <= LOAD;
              mem_re <= 1'b1;
            end
          end
        end
        STORE: begin
          if (last_lane) begin
            state  <= DONE;
            mem_we <= 1'b0;
            done   <= 1'b1;
          end
        end
        LOAD: begin
          if (last_lane) begin
            state  <= DRAIN;
            mem_re <= 1'b0;
          end
        end
        // The last read's data arrives here, so completion is signalled one cycle later than a store.
        DRAIN: begin
          state    <= DONE;
          done     <= 1'b1;
          ld_valid <= 1'b1;
          ld_dst   <= req_q.dst;
        end
        DONE: begin
          state     <= IDLE;
          done      <= 1'b0;
          ld_valid  <= 1'b0;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          mem_we    <= 1'b0;
          mem_re    <= 1'b0;
          done      <= 1'b0;
          ld_valid  <= 1'b0;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

  // Read data trails its strobe by one cycle; track which lane it belongs to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend <= 1'b0;
      rd_lane <= '0;
      ld_data <= '0;
    end else begin
      rd_pend <= mem_re;
      rd_lane <= lane;
      if (rd_pend) begin
        `CVP14_LANE(ld_data, rd_lane) <= mem_rdata;
      end
    end
  end

  assign mem_addr  = step ? gen_addr : '0;
  assign mem_wdata = mem_we ? `CVP14_LANE(req_q.wdata, lane) : '0;
endmodule

// File: tb/tb_vector_mem_unit.sv
// Directed-vector bench for vector_mem_unit with an event scoreboard and a 64K-word memory model.
module tb_vector_mem_unit;
  localparam logic [3:0] VLD = 4'b0100;
  localparam logic [3:0] VST = 4'b0101;
  localparam int EV_W = 0, EV_R = 1, EV_D = 2, EV_L = 3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid;
  logic         req_ready;
  logic [3:0]   req_opcode;
  logic [15:0]  req_addr;
  logic [255:0] req_wdata;
  logic [2:0]   req_dst;
`ifdef VMU_STRIDE_EN
  logic [15:0]  req_stride;
`endif
  logic [15:0]  mem_addr;
  logic         mem_re;
  logic         mem_we;
  logic [15:0]  mem_wdata;
  logic [15:0]  mem_rdata;
  logic         ld_valid;
  logic [255:0] ld_data;
  logic [2:0]   ld_dst;
  logic         done;

  logic [15:0]  mem [0:65535];
  int cyc = 0;
  int errors = 0;
  int checks = 0;

  typedef struct {
    int           kind;
    int           at;
    logic [15:0]  addr;
    logic [15:0]  d;
    logic [255:0] vec;
    logic [2:0]   dst;
  } ev_t;
  ev_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  vector_mem_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_opcode (req_opcode),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_dst    (req_dst),
`ifdef VMU_STRIDE_EN
    .req_stride (req_stride),
`endif
    .mem_addr   (mem_addr),
    .mem_re     (mem_re),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .ld_valid   (ld_valid),
    .ld_data    (ld_data),
    .ld_dst     (ld_dst),
    .done       (done)
  );

  task automatic push(input int kind, input int at, input logic [15:0] addr, input logic [15:0] d,
                      input logic [255:0] vec, input logic [2:0] dst);
    ev_t e;
    e.kind = kind; e.at = at; e.addr = addr; e.d = d; e.vec = vec; e.dst = dst;
    exp_q.push_back(e);
  endtask

  // Expected strobes for the first `keep` lanes; completion only for a full transfer.
  task automatic push_exp(input logic [3:0] op, input int t, input logic [15:0] base, input logic [15:0] stride,
                          input logic [255:0] vec, input logic [2:0] dst, input int keep);
    logic [15:0] a;
    for (int i = 0; i < keep; i++) begin
      a = base + 16'(i) * stride;
      if (op == VST) push(EV_W, t + 1 + i, a, vec[i*16 +: 16], '0, '0);
      else           push(EV_R, t + 1 + i, a, '0, '0, '0);
    end
    if (keep == 16) begin
      if (op == VST) push(EV_D, t + 17, '0, '0, '0, '0);
      else begin
        push(EV_D, t + 18, '0, '0, '0, '0);
        push(EV_L, t + 18, '0, '0, vec, dst);
      end
    end
  endtask

  task automatic observe(input int kind);
    ev_t e;
    logic ok;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event kind=%0d cyc=%0d addr=%h (nothing expected)", kind, cyc, mem_addr);
      return;
    end
    e = exp_q.pop_front();
    ok = (e.kind == kind) && (e.at == cyc);
    case (kind)
      EV_W: ok = ok && (mem_addr == e.addr) && (mem_wdata == e.d);
      EV_R: ok = ok && (mem_addr == e.addr);
      EV_L: ok = ok && (ld_data == e.vec) && (ld_dst == e.dst);
      default: ;
    endcase
    if (!ok) begin
      errors++;
      $display("FAIL event got/exp kind=%0d/%0d cyc=%0d/%0d addr=%h/%h wdata=%h/%h dst=%0d/%0d ld_data=%h/%h",
               kind, e.kind, cyc, e.at, mem_addr, e.addr, mem_wdata, e.d, ld_dst, e.dst, ld_data, e.vec);
    end
  endtask

  always @(negedge clk) begin
    if (mem_we && mem_re) begin
      checks++;
      errors++;
      $display("FAIL strobe_excl got we=1 re=1 exp not both, cyc=%0d", cyc);
    end
    if (mem_we)   observe(EV_W);
    if (mem_re)   observe(EV_R);
    if (done)     observe(EV_D);
    if (ld_valid) observe(EV_L);
  end

  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_req_ready"}, 256'(req_ready), 256'(1));
    chk({tag, "_ld_valid"},  256'(ld_valid),  256'(0));
    chk({tag, "_done"},      256'(done),      256'(0));
    chk({tag, "_mem_we"},    256'(mem_we),    256'(0));
    chk({tag, "_mem_re"},    256'(mem_re),    256'(0));
    chk({tag, "_mem_addr"},  256'(mem_addr),  256'(0));
    chk({tag, "_ld_dst"},    256'(ld_dst),    256'(0));
    chk({tag, "_ld_data"},   ld_data,         256'(0));
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Called just after a rising edge; pushes expectations before the accepting edge.
  task automatic issue(input logic [3:0] op, input logic [15:0] addr, input logic [255:0] vec,
                       input logic [2:0] dst, input logic [15:0] stride, input int keep, output int t);
    int n = 0;
    while (!req_ready && n < 100) begin tick(1); n++; end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_wait got req_ready=0 exp 1 within 100 cycles");
    end
    req_valid  = 1'b1;
    req_opcode = op;
    req_addr   = addr;
    req_wdata  = (op == VST) ? vec : ~vec;
    req_dst    = dst;
`ifdef VMU_STRIDE_EN
    req_stride = stride;
`endif
    t = cyc;
    push_exp(op, t, addr, stride, vec, dst, keep);
    tick(1);
    req_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin tick(1); n++; end
    tick(2);
    chk({name, "_drained"}, 256'(exp_q.size()), 256'(0));
    exp_q.delete();
  endtask

  function automatic logic [255:0] ramp(input logic [15:0] start);
    logic [255:0] v;
    for (int i = 0; i < 16; i++) v[i*16 +: 16] = start + 16'(i);
    return v;
  endfunction

  initial begin
    #400000;
    $display("FAIL timeout got no finish exp finish by 400us");
    $fatal(1, "timeout");
  end

  initial begin
    int t;
    logic [255:0] v;
    rst_n = 1'b0; req_valid = 1'b0; req_opcode = '0; req_addr = '0; req_wdata = '0; req_dst = '0;
`ifdef VMU_STRIDE_EN
    req_stride = 16'd1;
`endif
    tick(3);
    rst_n = 1'b1;
    tick(1);
    chk_reset("init");

    // Store lanes 0..15 at 0x0100, then a load held while the store is still running.
    issue(VST, 16'h0100, ramp(16'h0000), 3'd0, 16'd1, 16, t);
    req_valid = 1'b1; req_opcode = VLD; req_addr = 16'h0100; req_dst = 3'd5; req_wdata = '1;
`ifdef VMU_STRIDE_EN
    req_stride = 16'd1;
`endif
    push_exp(VLD, t + 18, 16'h0100, 16'd1, ramp(16'h0000), 3'd5, 16);
    while (cyc < t + 19) tick(1);
    req_valid = 1'b0;
    drain("st_ld_0100");

    // Mid-run reset clears the loaded vector.
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
    chk_reset("mid");

    // Address wrap past 0xFFFF for both store and load.
    issue(VST, 16'hFFF8, ramp(16'hC000), 3'd0, 16'd1, 16, t);
    drain("st_wrap");
    issue(VLD, 16'hFFF8, ramp(16'hC000), 3'd2, 16'd1, 16, t);
    drain("ld_wrap");

    // Store aborted by reset at T+8: lanes 0..6 land, the rest keep the older data.
    issue(VST, 16'h0200, ramp(16'hEE00), 3'd0, 16'd1, 16, t);
    drain("st_pre");
    issue(VST, 16'h0200, ramp(16'hB000), 3'd0, 16'd1, 7, t);
    while (cyc < t + 8) tick(1);
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    drain("abort");
    for (int i = 0; i < 16; i++) v[i*16 +: 16] = (i < 7) ? 16'hB000 + 16'(i) : 16'hEE00 + 16'(i);
    issue(VLD, 16'h0200, v, 3'd3, 16'd1, 16, t);
    drain("ld_after_abort");

    // Illegal opcodes must never handshake or touch memory.
    req_valid = 1'b1; req_opcode = 4'b0000; req_addr = 16'h0300; req_wdata = '1; req_dst = 3'd7;
    for (int i = 0; i < 6; i++) begin
      if (i == 3) req_opcode = 4'b0110;
      tick(1);
      chk("bad_op_ready", 256'(req_ready), 256'(1));
    end
    req_valid = 1'b0;
    drain("bad_op");

`ifdef VMU_STRIDE_EN
    issue(VST, 16'h0000, ramp(16'hD000), 3'd0, 16'd2, 16, t);
    drain("st_stride2");
    issue(VLD, 16'h0000, ramp(16'hD000), 3'd1, 16'd2, 16, t);
    drain("ld_stride2");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
